// File: rtl/seg7_scan_display_pkg.sv
// Shared constants, source-select encodings and segment table for the 4-digit
// hex scan display.
package seg7_scan_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic [1:0] {
        SEL_R2_LO = 2'b00,
        SEL_R2_HI = 2'b01,
        SEL_R3_LO = 2'b10,
        SEL_R3_HI = 2'b11
    } sel_e;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Pick the 16-bit half-word named by sel
    function automatic logic [15:0] sel_half(input logic [1:0]  sel,
                                             input logic [31:0] r2,
                                             input logic [31:0] r3);
        logic [15:0] h;
        case (sel)
            SEL_R2_LO: h = r2[15:0];
            SEL_R2_HI: h = r2[31:16];
            SEL_R3_LO: h = r3[15:0];
            default:   h = r3[31:16];
        endcase
        return h;
    endfunction

    // Index of the highest nonzero nibble; 0 when the value is zero
    function automatic logic [1:0] msd_index(input logic [15:0] v);
        logic [1:0] idx;
        if (v[15:12] != 4'h0)     idx = 2'd3;
        else if (v[11:8] != 4'h0) idx = 2'd2;
        else if (v[7:4] != 4'h0)  idx = 2'd1;
        else                      idx = 2'd0;
        return idx;
    endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// Purely combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import seg7_scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    // Table lookup
    always_comb begin
        seg_c = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Snapshots one selected 16-bit half-word per refresh frame and scans it as
// four hex digits onto a common-anode 7-segment display (active-low).
// Optional build macro: LEADING_ZERO_BLANK_EN darkens digits above the highest
// nonzero nibble (digit 0 always lit).
module seg7_scan_display
    import seg7_scan_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DIV_W       = 17
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] reg_2,
    input  logic [31:0] reg_3,
    input  logic [1:0]  sel,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [15:0]      snap_q, snap_d;
    logic             init_ld_q, init_ld_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic             tick_c;
    logic             load_c;
    logic             blank_c;
    logic [3:0]       nibble_c;
    logic [6:0]       dec_seg_c;

    hex_to_seg7 u_dec (
        .nibble (nibble_c),
        .seg_c  (dec_seg_c)
    );

    // Refresh timing, digit stepping, frame snapshot and output decode
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        digit_d    = digit_q;
        snap_d     = snap_q;
        init_ld_d  = 1'b0;
        an_d       = an_q;
        seg_d      = seg_q;
        dp_d       = 1'b1;

        tick_c   = (tick_cnt_q == DIV_W'(REFRESH_DIV - 1));
        load_c   = init_ld_q || (tick_c && (digit_q == 2'd3));
        nibble_c = snap_q[{digit_q, 2'b00} +: 4];

        tick_cnt_d = tick_c ? '0 : tick_cnt_q + DIV_W'(1);
        if (tick_c) begin
            digit_d = digit_q + 2'd1;
        end
        if (load_c) begin
            snap_d = sel_half(sel, reg_2, reg_3);
        end

        // The load cycle right after reset still holds a stale snapshot, so keep it dark
`ifdef LEADING_ZERO_BLANK_EN
        blank_c = init_ld_q || (digit_q > msd_index(snap_q));
`else
        blank_c = init_ld_q;
`endif

        an_d  = blank_c ? AN_OFF : ~(4'b0001 << digit_q);
        seg_d = blank_c ? SEG_BLANK : dec_seg_c;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            tick_cnt_q <= '0;
            digit_q    <= 2'd0;
            snap_q     <= 16'h0000;
            init_ld_q  <= 1'b1;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            digit_q    <= digit_d;
            snap_q     <= snap_d;
            init_ld_q  <= init_ld_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with a fast refresh (REFRESH_DIV=4).
module tb_seg7_scan_display;

    localparam int unsigned D = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] reg_2 = 32'h0;
    logic [31:0] reg_3 = 32'h0;
    logic [1:0]  sel = 2'b00;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 CLK = ~CLK;

    seg7_scan_display #(.REFRESH_DIV(D), .DIV_W(2)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .reg_2 (reg_2),
        .reg_3 (reg_3),
        .sel   (sel),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] pick(input logic [1:0] s, input logic [31:0] a,
                                         input logic [31:0] b);
        case (s)
            2'd0:    return a[15:0];
            2'd1:    return a[31:16];
            2'd2:    return b[15:0];
            default: return b[31:16];
        endcase
    endfunction

    function automatic int top_nz(input logic [15:0] v);
        for (int i = 3; i > 0; i--) begin
            if (((v >> (4 * i)) & 16'hF) != 16'h0) return i;
        end
        return 0;
    endfunction

    // Model: k = clock edges since reset release; output at edge k reflects edge k-1
    int          k = 0;
    int          md;
    logic [3:0]  mnib;
    logic [15:0] msnap = 16'h0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    bit          mvalid = 1'b0;

    always @(posedge CLK) begin
        if (RST) begin
            k       = 0;
            msnap   = 16'h0;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
        end else begin
            if (k == 0) begin
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
            end else begin
                md      = (k / D) % 4;
                mnib    = 4'(msnap >> (4 * md));
                exp_an  = 4'hF ^ 4'(1 << md);
                exp_seg = tbl[mnib];
`ifdef LEADING_ZERO_BLANK_EN
                if (md > top_nz(msnap)) begin
                    exp_an  = 4'hF;
                    exp_seg = 7'h7F;
                end
`endif
            end
            k++;
            if (k == 1 || (k % (4 * D)) == 0) msnap = pick(sel, reg_2, reg_3);
        end
        mvalid = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (mvalid) chk("model", {20'h0, an, seg, dp}, {20'h0, exp_an, exp_seg, 1'b1});
    end

    int rel = 0;

    task automatic adv_to(input int t);
        while (rel < t) begin
            @(negedge CLK);
            rel++;
        end
    endtask

    task automatic lit(input string nm, input int t, input logic [3:0] a, input logic [6:0] s);
        adv_to(t);
        chk(nm, {20'h0, an, seg, dp}, {20'h0, a, s, 1'b1});
    endtask

    initial begin
        reg_2 = 32'h0000_1234;
        sel   = 2'b00;
        repeat (3) begin
            @(negedge CLK);
            chk("reset_dark", {20'h0, an, seg, dp}, {20'h0, 4'hF, 7'h7F, 1'b1});
        end
        RST = 1'b0;
        rel = 0;

        lit("init_dark",  1, 4'hF, 7'h7F);
        lit("f1_d0",      2, 4'hE, 7'h19);
        lit("f1_d1",      5, 4'hD, 7'h30);
        lit("f1_d2",      9, 4'hB, 7'h24);
        adv_to(10);
        sel   = 2'b11;
        reg_3 = 32'hBEEF_0000;
        lit("f1_d3_hold", 13, 4'h7, 7'h79);
        lit("f2_d0",      17, 4'hE, 7'h0E);
        adv_to(20);
        sel = 2'b00;

        for (int r = 21; r <= 48; r++) begin
            adv_to(r);
            case (r)
                21: chk("f2_d1", {20'h0, an, seg, dp}, {20'h0, 4'hD, 7'h06, 1'b1});
                25: chk("f2_d2", {20'h0, an, seg, dp}, {20'h0, 4'hB, 7'h06, 1'b1});
                29: chk("f2_d3", {20'h0, an, seg, dp}, {20'h0, 4'h7, 7'h03, 1'b1});
                33: chk("f3_d0", {20'h0, an, seg, dp}, {20'h0, 4'hE, 7'h0E, 1'b1});
                41: chk("f3_d2", {20'h0, an, seg, dp}, {20'h0, 4'hB, 7'h40, 1'b1});
                45: chk("f3_d3", {20'h0, an, seg, dp}, {20'h0, 4'h7, 7'h08, 1'b1});
                default: ;
            endcase
            if (r >= 26 && r <= 40) reg_2 = 32'h0000_A000 + 32'(r);
        end

        adv_to(50);
        sel   = 2'b10;
        reg_3 = 32'h0000_5678;
        adv_to(56);
        RST = 1'b1;
        lit("midrst_dark", 57, 4'hF, 7'h7F);
        RST = 1'b0;
        lit("rel_dark",    58, 4'hF, 7'h7F);
        lit("rel_d0",      59, 4'hE, 7'h00);

        adv_to(60);
        sel   = 2'b00;
        reg_2 = 32'h0000_0042;
        lit("lz_d0", 74, 4'hE, 7'h24);
        lit("lz_d1", 78, 4'hD, 7'h19);
`ifdef LEADING_ZERO_BLANK_EN
        lit("lz_d2", 82, 4'hF, 7'h7F);
        lit("lz_d3", 86, 4'hF, 7'h7F);
`else
        lit("lz_d2", 82, 4'hB, 7'h40);
        lit("lz_d3", 86, 4'h7, 7'h40);
`endif
        adv_to(87);
        reg_2 = 32'h0;
        lit("zero_d0", 90, 4'hE, 7'h40);
`ifdef LEADING_ZERO_BLANK_EN
        lit("zero_d1", 94, 4'hF, 7'h7F);
`else
        lit("zero_d1", 94, 4'hD, 7'h40);
`endif
        adv_to(96);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
